// File: rtl/tl_dbg_master.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : tl_dbg_master
// Brief   : Single-outstanding TileLink-UL initiator (Get / PutFullData) for debug access.
// Rev     : 1.0  initial release
// ----------------------------------------------------------------------------
module tl_dbg_master #(
  parameter int TIMEOUT   = 1024,
  parameter int SOURCE_ID = 0,
  parameter int SRC_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_req_valid,
  output logic             o_req_ready,
  input  logic             i_req_write,
  input  logic [2:0]       i_req_size,
  input  logic [63:0]      i_req_addr,
  input  logic [63:0]      i_req_wdata,
  output logic             o_resp_valid,
  output logic [63:0]      o_resp_rdata,
  output logic             o_resp_err,
  output logic             o_busy,
  output logic             o_a_valid,
  input  logic             i_a_ready,
  output logic [2:0]       o_a_opcode,
  output logic [2:0]       o_a_size,
  output logic [SRC_W-1:0] o_a_source,
  output logic [63:0]      o_a_address,
  output logic [7:0]       o_a_mask,
  output logic [63:0]      o_a_data,
  input  logic             i_d_valid,
  output logic             o_d_ready,
  input  logic [2:0]       i_d_opcode,
  input  logic [SRC_W-1:0] i_d_source,
  input  logic [63:0]      i_d_data
);

  localparam logic [2:0] c_TL_PUT_F           = 3'd0;
  localparam logic [2:0] c_TL_GET             = 3'd4;
  localparam logic [2:0] c_TL_ACCESS_ACK      = 3'd0;
  localparam logic [2:0] c_TL_ACCESS_ACK_DATA = 3'd1;

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_ACMD  = 2'd1;
  localparam logic [1:0] c_DWAIT = 2'd2;
  localparam logic [1:0] c_RESP  = 2'd3;

  localparam int                 c_CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [c_CNT_W-1:0] c_TMAX  = (TIMEOUT > 1) ? c_CNT_W'(TIMEOUT - 1) : '0;
  localparam logic               c_TO_EN = (TIMEOUT != 0);
  localparam logic [SRC_W-1:0]   c_SRC   = SRC_W'(SOURCE_ID);

  logic [1:0]         r_state;
  logic [1:0]         w_next;
  logic               r_write;
  logic [2:0]         r_size;
  logic [63:0]        r_addr;
  logic [63:0]        r_wdata;
  logic [c_CNT_W-1:0] r_cnt;
  logic [63:0]        r_rdata;
  logic               r_err;

  logic [2:0]  w_req_len_m1;
  logic        w_req_bad;
  logic [5:0]  w_shift;
  logic [7:0]  w_mask_base;
  logic [63:0] w_byte_mask;
  logic        w_expire;
  logic [2:0]  w_exp_dop;
  logic        w_d_bad;
  logic [63:0] w_d_rdata;
  logic        w_load_resp;
  logic        w_next_err;
  logic [63:0] w_next_rdata;

  // Request legality is judged on the live inputs so a bad command never touches the bus.
  always_comb begin
    w_req_len_m1 = 3'd0;
    case (i_req_size[1:0])
      2'd0:    w_req_len_m1 = 3'd0;
      2'd1:    w_req_len_m1 = 3'd1;
      2'd2:    w_req_len_m1 = 3'd3;
      default: w_req_len_m1 = 3'd7;
    endcase
  end

  assign w_req_bad = (i_req_size > 3'd3) || ((i_req_addr[2:0] & w_req_len_m1) != 3'd0);

  always_comb begin
    w_mask_base = 8'h01;
    w_byte_mask = 64'h0000_0000_0000_00FF;
    case (r_size[1:0])
      2'd0: begin
        w_mask_base = 8'h01;
        w_byte_mask = 64'h0000_0000_0000_00FF;
      end
      2'd1: begin
        w_mask_base = 8'h03;
        w_byte_mask = 64'h0000_0000_0000_FFFF;
      end
      2'd2: begin
        w_mask_base = 8'h0F;
        w_byte_mask = 64'h0000_0000_FFFF_FFFF;
      end
      default: begin
        w_mask_base = 8'hFF;
        w_byte_mask = 64'hFFFF_FFFF_FFFF_FFFF;
      end
    endcase
  end

  assign w_shift   = {r_addr[2:0], 3'b000};
  assign w_expire  = c_TO_EN && (r_cnt == c_TMAX);
  assign w_exp_dop = r_write ? c_TL_ACCESS_ACK : c_TL_ACCESS_ACK_DATA;
  assign w_d_bad   = (i_d_source != c_SRC) || (i_d_opcode != w_exp_dop);
  assign w_d_rdata = (i_d_data >> w_shift) & w_byte_mask;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Handshakes are tested before expiry so a completion in the last cycle wins.
  always_comb begin
    w_next       = r_state;
    w_next_err   = 1'b1;
    w_next_rdata = '0;
    case (r_state)
      c_IDLE: begin
        if (i_req_valid) begin
          w_next = w_req_bad ? c_RESP : c_ACMD;
        end
      end
      c_ACMD: begin
        if (i_a_ready) begin
          w_next = c_DWAIT;
        end else if (w_expire) begin
          w_next = c_RESP;
        end
      end
      c_DWAIT: begin
        if (i_d_valid) begin
          w_next       = c_RESP;
          w_next_err   = w_d_bad;
          w_next_rdata = (w_d_bad || r_write) ? '0 : w_d_rdata;
        end else if (w_expire) begin
          w_next = c_RESP;
        end
      end
      default: begin
        w_next = c_IDLE;
      end
    endcase
  end

  assign w_load_resp = (w_next == c_RESP) && (r_state != c_RESP);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_write <= 1'b0;
      r_size  <= 3'd0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_cnt   <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      if (r_state == c_IDLE) begin
        r_cnt <= '0;
        if (i_req_valid) begin
          r_write <= i_req_write;
          r_size  <= i_req_size;
          r_addr  <= i_req_addr;
          r_wdata <= i_req_wdata;
        end
      end else if (((r_state == c_ACMD) || (r_state == c_DWAIT)) && (r_cnt != c_TMAX)) begin
        r_cnt <= r_cnt + c_CNT_W'(1);
      end
      if (w_load_resp) begin
        r_err   <= w_next_err;
        r_rdata <= w_next_rdata;
      end
    end
  end

  always_comb begin
    o_req_ready  = (r_state == c_IDLE);
    o_a_valid    = (r_state == c_ACMD);
    o_d_ready    = (r_state == c_DWAIT);
    o_resp_valid = (r_state == c_RESP);
    o_busy       = (r_state != c_IDLE);
    o_resp_err   = r_err && (r_state == c_RESP);
  end

  assign o_resp_rdata = r_rdata;
  assign o_a_opcode   = r_write ? c_TL_PUT_F : c_TL_GET;
  assign o_a_size     = r_size;
  assign o_a_source   = c_SRC;
  assign o_a_address  = r_addr;
  assign o_a_mask     = w_mask_base << r_addr[2:0];
  assign o_a_data     = r_write ? (r_wdata << w_shift) : '0;

endmodule
`default_nettype wire

// File: tb/tb_tl_dbg_master.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : tb_tl_dbg_master
// Brief   : Directed table plus randomized transactions against a reference model.
// Rev     : 1.0  initial release
// ----------------------------------------------------------------------------
module tb_tl_dbg_master;

  localparam int         TO      = 16;
  localparam logic [2:0] OP_PUT  = 3'd0;
  localparam logic [2:0] OP_GET  = 3'd4;
  localparam logic [2:0] OP_ACK  = 3'd0;
  localparam logic [2:0] OP_ACKD = 3'd1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_req_valid = 1'b0;
  logic        o_req_ready;
  logic        i_req_write = 1'b0;
  logic [2:0]  i_req_size = 3'd0;
  logic [63:0] i_req_addr = '0;
  logic [63:0] i_req_wdata = '0;
  logic        o_resp_valid;
  logic [63:0] o_resp_rdata;
  logic        o_resp_err;
  logic        o_busy;
  logic        o_a_valid;
  logic        i_a_ready = 1'b0;
  logic [2:0]  o_a_opcode;
  logic [2:0]  o_a_size;
  logic [7:0]  o_a_source;
  logic [63:0] o_a_address;
  logic [7:0]  o_a_mask;
  logic [63:0] o_a_data;
  logic        i_d_valid = 1'b0;
  logic        o_d_ready;
  logic [2:0]  i_d_opcode = 3'd0;
  logic [7:0]  i_d_source = 8'd0;
  logic [63:0] i_d_data = '0;

  always #5 clk = ~clk;

  tl_dbg_master #(.TIMEOUT(TO), .SOURCE_ID(0), .SRC_W(8)) u_dut (
    .clk(clk), .rst(rst),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready), .i_req_write(i_req_write),
    .i_req_size(i_req_size), .i_req_addr(i_req_addr), .i_req_wdata(i_req_wdata),
    .o_resp_valid(o_resp_valid), .o_resp_rdata(o_resp_rdata), .o_resp_err(o_resp_err),
    .o_busy(o_busy),
    .o_a_valid(o_a_valid), .i_a_ready(i_a_ready), .o_a_opcode(o_a_opcode), .o_a_size(o_a_size),
    .o_a_source(o_a_source), .o_a_address(o_a_address), .o_a_mask(o_a_mask), .o_a_data(o_a_data),
    .i_d_valid(i_d_valid), .o_d_ready(o_d_ready), .i_d_opcode(i_d_opcode),
    .i_d_source(i_d_source), .i_d_data(i_d_data)
  );

  typedef struct {
    logic        wr;
    logic [2:0]  size;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] ddata;
    int          ad;
    int          dd;
    logic [2:0]  dop;
    logic [7:0]  dsrc;
    logic        silent;
    logic        junk;
    logic        exp_err;
    logic [63:0] exp_rdata;
    logic [7:0]  exp_mask;
    logic [63:0] exp_adata;
    int          exp_lat;
    logic        exp_bus;
  } vec_t;

  int    errors = 0;
  int    checks = 0;
  string g_tag  = "init";

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s.%s: got 0x%0h expected 0x%0h", g_tag, name, act, exp);
    end
  endtask

  function automatic vec_t mkv(input logic wr, input logic [2:0] size, input logic [63:0] addr,
                               input logic [63:0] wdata, input logic [63:0] ddata,
                               input int ad, input int dd, input logic [2:0] dop,
                               input logic [7:0] dsrc, input logic silent, input logic junk,
                               input logic exp_err, input logic [63:0] exp_rdata,
                               input logic [7:0] exp_mask, input logic [63:0] exp_adata,
                               input int exp_lat, input logic exp_bus);
    vec_t v;
    v.wr = wr; v.size = size; v.addr = addr; v.wdata = wdata; v.ddata = ddata;
    v.ad = ad; v.dd = dd; v.dop = dop; v.dsrc = dsrc; v.silent = silent; v.junk = junk;
    v.exp_err = exp_err; v.exp_rdata = exp_rdata; v.exp_mask = exp_mask;
    v.exp_adata = exp_adata; v.exp_lat = exp_lat; v.exp_bus = exp_bus;
    return v;
  endfunction

  // Reference model: byte-lane arithmetic and cycle accounting from the transaction rules.
  function automatic vec_t model(input vec_t v);
    vec_t r;
    int   off;
    int   nbytes;
    int   dcyc;
    bit   legal;
    bit   good;
    r   = v;
    off = int'(v.addr[2:0]);
    legal = (v.size <= 3'd3) && ((off % (1 << v.size)) == 0);
    r.exp_bus   = legal;
    r.exp_mask  = '0;
    r.exp_adata = '0;
    r.exp_rdata = '0;
    if (!legal) begin
      r.exp_err = 1'b1;
      r.exp_lat = 1;
      return r;
    end
    nbytes = 1 << v.size;
    if (v.wr) r.exp_adata = v.wdata << (8 * off);
    for (int b = 0; b < 8; b++) begin
      if (b >= off && b < off + nbytes) begin
        r.exp_mask[b] = 1'b1;
        r.exp_rdata[8*(b-off) +: 8] = v.ddata[8*b +: 8];
      end
    end
    dcyc = v.silent ? 1000 : 2 + v.ad + v.dd;
    if (dcyc <= TO) begin
      r.exp_lat = dcyc + 1;
      good = (v.dsrc == 8'd0) && (v.dop == (v.wr ? OP_ACK : OP_ACKD));
      r.exp_err = !good;
      if (!good || v.wr) r.exp_rdata = '0;
    end else begin
      r.exp_lat   = TO + 1;
      r.exp_err   = 1'b1;
      r.exp_rdata = '0;
    end
    return r;
  endfunction

  task automatic run_txn(input vec_t v);
    int          resp_cyc = -1;
    int          pulses = 0;
    bit          a_seen = 1'b0;
    bit          a_ok = 1'b1;
    bit          busy_ok = 1'b1;
    bit          jk;
    logic [63:0] rd = '0;
    logic        er = 1'b0;
    @(negedge clk);
    chk("req_ready", 64'(o_req_ready), 64'd1);
    i_req_valid = 1'b1;
    i_req_write = v.wr;
    i_req_size  = v.size;
    i_req_addr  = v.addr;
    i_req_wdata = v.wdata;
    @(negedge clk);
    i_req_valid = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      if (resp_cyc < 0 && !o_busy) busy_ok = 1'b0;
      if (o_resp_valid) begin
        pulses++;
        if (resp_cyc < 0) begin
          resp_cyc = k;
          rd = o_resp_rdata;
          er = o_resp_err;
        end
      end
      if (o_a_valid) begin
        a_seen = 1'b1;
        if (o_a_opcode !== (v.wr ? OP_PUT : OP_GET) || o_a_size !== v.size ||
            o_a_address !== v.addr || o_a_source !== 8'd0 ||
            o_a_mask !== v.exp_mask || o_a_data !== v.exp_adata) a_ok = 1'b0;
      end
      if (resp_cyc > 0 && k == resp_cyc + 1) begin
        chk("idle_after", 64'({o_busy, o_req_ready}), 64'd1);
        chk("rdata_hold", o_resp_rdata, rd);
        break;
      end
      jk = v.exp_bus && v.junk && (k == 1 + v.ad);
      i_a_ready  = v.exp_bus && (k == 1 + v.ad);
      i_d_valid  = jk || (v.exp_bus && !v.silent && (k == 2 + v.ad + v.dd));
      i_d_opcode = jk ? (v.wr ? OP_ACKD : OP_ACK) : v.dop;
      i_d_source = v.dsrc;
      i_d_data   = jk ? 64'hDEAD_BEEF_DEAD_BEEF : v.ddata;
      @(negedge clk);
    end
    i_a_ready = 1'b0;
    i_d_valid = 1'b0;
    chk("resp_cycle", 64'(resp_cyc), 64'(v.exp_lat));
    chk("resp_pulses", 64'(pulses), 64'd1);
    chk("resp_err", 64'(er), 64'(v.exp_err));
    chk("resp_rdata", rd, v.exp_rdata);
    chk("a_seen", 64'(a_seen), 64'(v.exp_bus));
    chk("a_fields", 64'(a_ok), 64'd1);
    chk("busy", 64'(busy_ok), 64'd1);
  endtask

  vec_t tbl[12];
  vec_t rv;
  int   s;

  initial begin
    tbl[0]  = mkv(1, 3, 64'h8000_0010, 64'h1122_3344_5566_7788, 64'h0, 0, 0, OP_ACK, 0, 0, 0,
                  0, 64'h0, 8'hFF, 64'h1122_3344_5566_7788, 3, 1);
    tbl[1]  = mkv(0, 1, 64'h8000_0006, 64'h0, 64'hAABB_CCDD_1122_3344, 0, 0, OP_ACKD, 0, 0, 0,
                  0, 64'hAABB, 8'hC0, 64'h0, 3, 1);
    tbl[2]  = mkv(1, 2, 64'h8000_0003, 64'h1234_5678, 64'h0, 0, 0, OP_ACK, 0, 0, 0,
                  1, 64'h0, 8'h00, 64'h0, 1, 0);
    tbl[3]  = mkv(0, 3, 64'h100, 64'h0, 64'h0123_4567_89AB_CDEF, 5, 7, OP_ACKD, 0, 0, 1,
                  0, 64'h0123_4567_89AB_CDEF, 8'hFF, 64'h0, 15, 1);
    tbl[4]  = mkv(0, 2, 64'hC, 64'h0, 64'h5555_6666_7777_8888, 0, 0, OP_ACK, 0, 0, 0,
                  1, 64'h0, 8'hF0, 64'h0, 3, 1);
    tbl[5]  = mkv(0, 0, 64'h5, 64'h0, 64'h0000_AA00_0000_0000, 0, 0, OP_ACKD, 1, 0, 0,
                  1, 64'h0, 8'h20, 64'h0, 3, 1);
    tbl[6]  = mkv(0, 3, 64'h0, 64'h0, 64'h0, 0, 0, OP_ACKD, 0, 1, 0,
                  1, 64'h0, 8'hFF, 64'h0, 17, 1);
    tbl[7]  = mkv(0, 4, 64'h0, 64'h0, 64'h0, 0, 0, OP_ACKD, 0, 0, 0,
                  1, 64'h0, 8'h00, 64'h0, 1, 0);
    tbl[8]  = mkv(0, 0, 64'h7, 64'h0, 64'hFE00_0000_0000_0000, 0, 0, OP_ACKD, 0, 0, 0,
                  0, 64'hFE, 8'h80, 64'h0, 3, 1);
    tbl[9]  = mkv(1, 1, 64'h2, 64'hBEEF, 64'h0, 0, 0, OP_ACK, 0, 0, 0,
                  0, 64'h0, 8'h0C, 64'hBEEF_0000, 3, 1);
    tbl[10] = mkv(0, 3, 64'h40, 64'h0, 64'hCAFE_F00D_1234_5678, 0, 14, OP_ACKD, 0, 0, 0,
                  0, 64'hCAFE_F00D_1234_5678, 8'hFF, 64'h0, 17, 1);
    tbl[11] = mkv(0, 3, 64'h48, 64'h0, 64'h1, 0, 15, OP_ACKD, 0, 0, 0,
                  1, 64'h0, 8'hFF, 64'h0, 17, 1);

    repeat (3) @(negedge clk);
    g_tag = "reset";
    chk("req_ready", 64'(o_req_ready), 64'd1);
    chk("busy", 64'(o_busy), 64'd0);
    chk("a_valid", 64'(o_a_valid), 64'd0);
    chk("d_ready", 64'(o_d_ready), 64'd0);
    chk("resp_valid", 64'(o_resp_valid), 64'd0);
    chk("resp_err", 64'(o_resp_err), 64'd0);
    chk("resp_rdata", o_resp_rdata, 64'd0);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      g_tag = $sformatf("vec%0d", i);
      run_txn(tbl[i]);
    end

    // Reset while waiting for D, then a late D beat that must be ignored.
    g_tag = "rst_dwait";
    @(negedge clk);
    i_req_valid = 1'b1; i_req_write = 1'b0; i_req_size = 3'd3; i_req_addr = 64'h20;
    @(negedge clk);
    i_req_valid = 1'b0;
    chk("a_valid", 64'(o_a_valid), 64'd1);
    i_a_ready = 1'b1;
    @(negedge clk);
    i_a_ready = 1'b0;
    chk("d_ready", 64'(o_d_ready), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("post_rst", 64'({o_busy, o_d_ready, o_a_valid, o_resp_valid}), 64'd0);
    i_d_valid = 1'b1; i_d_opcode = OP_ACKD; i_d_source = 8'd0; i_d_data = 64'h5A5A;
    @(negedge clk);
    i_d_valid = 1'b0;
    chk("late_beat", 64'({o_resp_valid, o_busy, o_req_ready}), 64'd1);
    g_tag = "after_rst";
    run_txn(tbl[1]);

    for (int i = 0; i < 40; i++) begin
      rv = mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      rv.wr    = 1'($urandom_range(0, 1));
      rv.size  = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
      rv.addr  = {$urandom, $urandom};
      if (rv.size <= 3'd3 && $urandom_range(0, 3) != 0) begin
        s = int'(rv.size);
        rv.addr[2:0] = 3'((int'(rv.addr[2:0]) >> s) << s);
      end
      rv.wdata  = {$urandom, $urandom};
      rv.ddata  = {$urandom, $urandom};
      rv.ad     = $urandom_range(0, 5);
      rv.dd     = $urandom_range(0, 5);
      rv.dop    = (rv.wr ? OP_ACK : OP_ACKD) ^ (($urandom_range(0, 7) == 0) ? 3'd1 : 3'd0);
      rv.dsrc   = ($urandom_range(0, 9) == 0) ? 8'd3 : 8'd0;
      rv.silent = ($urandom_range(0, 14) == 0);
      rv.junk   = ($urandom_range(0, 3) == 0);
      rv = model(rv);
      g_tag = $sformatf("rnd%0d", i);
      run_txn(rv);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/tl_dbg_master.md
Name: tl_dbg_master

Overview:
- Single-outstanding TileLink-UL initiator for debug and test access to any TileLink slave, e.g. the RAM.
- Takes simple read and write commands from a debug controller or testbench and issues one A-channel Get or PutFullData.
- Waits for the matching D-channel AccessAck or AccessAckData, then returns aligned read data and an error flag.
- Sits on the master end of the same tilelink interface that the RAM slave and its monitor observe.

Parameters:
TIMEOUT, 1024, cycles allowed from leaving IDLE to D response before the command is aborted with error; 0 disables the timeout.
SOURCE_ID, 0, constant driven on a_source and checked on d_source.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_valid  in  1  command valid
req_ready  out  1  command accepted this cycle, high only in IDLE
req_write  in  1  1 = Put, 0 = Get
req_size  in  3  log2 of bytes; legal values 0..3
req_addr  in  64  byte address
req_wdata  in  64  write data, right-justified
resp_valid  out  1  one-cycle completion pulse
resp_rdata  out  64  read data, right-justified and zero-extended; 0 for writes and errors
resp_err  out  1  qualified by resp_valid
busy  out  1  state != IDLE
bus  tilelink.master  -  A/D channels: a_valid/a_ready/a_opcode/a_size/a_source/a_address/a_mask/a_data, d_valid/d_ready/d_opcode/d_source/d_data

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset values: state = IDLE; a_valid, d_ready, resp_valid, resp_err, busy = 0; resp_rdata = 0; timeout counter = 0.
- Reset mid-operation: return to IDLE next edge and drop a_valid. An in-flight D beat arriving after reset is ignored (d_ready = 0).
- States: IDLE, ACMD, DWAIT, RESP.

IDLE:
- req_ready = 1.
- On req_valid, latch write, size, addr and wdata.
- Alignment check: addr[2:0] & ((1<<size)-1) must be 0, and size must be <= 3.
- Misaligned or size > 3: go to RESP with err = 1, and drive no bus activity.
- Otherwise go to ACMD and clear the counter.

ACMD:
- a_valid = 1. Fields are held stable until a_ready.
- a_opcode = TL_PUT_F if write, else TL_GET.
- a_size = size; a_address = addr; a_source = SOURCE_ID.
- a_mask = ((1<<(1<<size))-1) << addr[2:0], 8 bits.
- a_data = wdata << (addr[2:0]*8); 0 for Get.
- On a_valid & a_ready, go to DWAIT.

DWAIT:
- d_ready = 1.
- On d_valid, check the response:
  - err = (d_source != SOURCE_ID), or d_opcode != (write ? TL_ACCESS_ACK : TL_ACCESS_ACK_DATA).
  - For a good Get, rdata = (d_data >> (addr[2:0]*8)) masked to (1<<size) bytes.
- Go to RESP.
- A D beat that arrives in the same cycle as the A handshake is not accepted; it waits for DWAIT.

RESP:
- resp_valid = 1 for exactly one cycle with rdata/err, then IDLE.
- Next command acceptance is possible two cycles after RESP is entered.
- resp_rdata holds its value until the next RESP.

Timeout:
- The counter increments every cycle in ACMD and DWAIT.
- When counter == TIMEOUT-1 without the handshake or response completing: drop a_valid and d_ready, go to RESP with err = 1, rdata = 0.
- A D beat arriving in the expiry cycle wins over the timeout.

Minimum latency: req handshake to resp_valid = 3 cycles when a_ready and d_valid each respond in one cycle.

Test Plan:
- Put size=3, addr=0x80000010, wdata=0x1122334455667788 with a slave that acks immediately -> a_opcode=PUT_F, a_mask=0xFF, a_data unchanged; resp_valid 3 cycles after accept, err=0, rdata=0.
- Get size=1, addr=0x80000006, slave returns d_data=0xAABBCCDD11223344 with AccessAckData -> a_mask=0xC0; resp_rdata=0x000000000000AABB, err=0.
- Put size=2, addr=0x80000003 -> no a_valid ever asserted; resp_valid next cycle with err=1.
- a_ready held low 5 cycles, then d_valid delayed 7 cycles -> a_* fields stable throughout; single resp_valid pulse; busy high for the whole transaction.
- Get with wrong d_opcode (AccessAck), and a separate Get with d_source=SOURCE_ID+1 -> err=1 each, rdata=0; then slave silent with TIMEOUT=16 -> resp_valid err=1 exactly 16 cycles after leaving IDLE.
- rst asserted while in DWAIT -> next cycle busy=0, d_ready=0, a_valid=0, no resp_valid; a new command is accepted cleanly afterwards.
